mac_pe_os: RTL and testbench
============================

MAC_PE_OS -- requirements
Module: mac_pe_os

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  DATA_WIDTH  16  signed operand width
  ACC_WIDTH   40  signed accumulator width, must be at least 2*DATA_WIDTH
  OUT_WIDTH   16  result width
  FRAC_BITS   0   arithmetic right shift applied before narrowing
  MUL_PIPE    1   product pipeline stages, 0..2
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  i_clk  in  1  clock
  i_rst  in  1  reset
  i_en  in  1  global advance; 0 freezes all state
  iv_a / iv_b  in  DATA_WIDTH  operands
  i_valid  in  1  operand pair valid
  i_last  in  1  final pair of a dot product
  ov_a / ov_b  out  DATA_WIDTH  forwarded operands
  o_valid / o_last  out  1  forwarded qualifiers
  iv_drain  in  OUT_WIDTH  neighbour result
  i_drain_valid  in  1  neighbour result valid
  o_drain_ready  out  1  drain accept
  ov_result  out  OUT_WIDTH  result word
  o_result_valid  out  1  result valid
  i_result_ready  in  1  downstream accept
  o_ovf  out  1  sticky lost-result flag
REQ-003 SHALL use one clock; reset is synchronous and active-high (i_clk, i_rst).

Function
REQ-004 SHALL forward iv_a, iv_b, i_valid and i_last to ov_a, ov_b, o_valid and o_last with exactly 1 cycle latency when i_en=1, independent of MUL_PIPE.
REQ-005 SHALL treat operands as signed; the full 2*DATA_WIDTH product is sign-extended to ACC_WIDTH; the accumulator wraps in two's complement.
REQ-006 SHALL delay the product, valid and last together by MUL_PIPE register stages.
REQ-007 SHALL add only valid products to the accumulator; invalid cycles leave it unchanged.
REQ-008 SHALL, on a valid product with last=1, capture acc+product as the final value and clear the accumulator to 0 on the same edge; the next valid product starts a new sum.
REQ-009 SHALL narrow the final value as (final >>> FRAC_BITS), then truncate to OUT_WIDTH; REQ-017 overrides this when MAC_SAT_EN is defined.
REQ-010 SHALL present a local result on ov_result/o_result_valid after edge t+MUL_PIPE+2, where its last pair was sampled at edge t, provided the output register is free.
REQ-011 SHALL consume the output word on a cycle with o_result_valid=1 and i_result_ready=1; an unconsumed word SHALL hold stable.
REQ-012 SHALL use a 1-entry hold register; when the output register is free, it SHALL load from sources in priority order: local result, then hold, then drain.
REQ-013 SHALL define o_drain_ready = hold empty AND no local result pending; a drain word is accepted when i_drain_valid=1, o_drain_ready=1 and i_en=1.
REQ-014 SHALL route a blocked local result, or an accepted drain word that loses arbitration, into the hold register.
REQ-015 SHALL drop a local result that finds both the output and hold registers occupied, and SHALL set o_ovf; o_ovf SHALL stay set until reset.
REQ-016 SHALL, when i_en=0, hold every register, output ready/valid and in-flight product unchanged.

Configuration
REQ-017 SHALL, with MAC_SAT_EN defined, saturate the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; without MAC_SAT_EN it SHALL truncate to the low OUT_WIDTH bits, and no saturation logic SHALL be present.

Reset
REQ-018 SHALL, while i_rst=1, clear ov_a, ov_b, o_valid, o_last, ov_result, o_result_valid, o_ovf, the accumulator, the pipeline valids and the hold register; o_drain_ready reads 1 after reset.
REQ-019 SHALL discard partial sums and pending results on a mid-operation reset; reset overrides i_en.

Structure
REQ-020 SHALL place width defaults, the MUL_PIPE bound and the saturate/truncate helper function in package mac_pkg.
REQ-021 SHALL implement the product pipeline as sub-module mac_mult_pipe, with parameters DATA_WIDTH and MUL_PIPE and carrying product, valid and last.

Verification
REQ-022 SHALL cover, with defaults (MUL_PIPE=1), the pairs (3,4), (-2,5), (7,1) with last on the third pair -> ov_result=9 after edge t+3, then the accumulator reads 0.
REQ-023 SHALL cover MAC_SAT_EN with (32767,32767)x2 and last -> ov_result=0x7FFF; without the macro -> the low 16 bits of 2147352578, i.e. 0x0002.
REQ-024 SHALL cover a drain word 0x00AA and a local result 0x0011 in the same cycle with i_result_ready=1 -> 0x0011, then 0x00AA on consecutive cycles; o_drain_ready=0 during that cycle.
REQ-025 SHALL cover i_result_ready=0 with three local results arriving -> the first is held, the second goes to hold, the third is dropped and o_ovf=1.
REQ-026 SHALL cover i_en=0 for 5 cycles in the middle of a sum -> outputs frozen, and the final result is identical to an uninterrupted run.
REQ-027 SHALL cover i_rst pulsed after two of three pairs -> all outputs 0, and the next three-pair sum excludes the earlier pairs.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults, pipeline bound and result-narrowing helper for the output-stationary MAC PE.
// Optional macro MAC_SAT_EN: saturate narrowed results instead of truncating them.
package mac_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ACC_W_DEF     = 40;
    localparam int OUT_W_DEF     = 16;
    localparam int FRAC_BITS_DEF = 0;
    localparam int MUL_PIPE_DEF  = 1;
    localparam int MUL_PIPE_MAX  = 2;
    localparam int ACC_MAX_W     = 64;

    // Reduce an already-shifted value to out_w bits; the caller keeps the low out_w bits.
    function automatic logic signed [ACC_MAX_W-1:0] narrow_word(
        input logic signed [ACC_MAX_W-1:0] v,
        input int unsigned                 out_w
    );
`ifdef MAC_SAT_EN
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        hi = (ACC_MAX_W'(1) << (out_w - 1)) - ACC_MAX_W'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return v & ((ACC_MAX_W'(1) << out_w) - ACC_MAX_W'(1));
`endif
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Signed multiplier followed by MUL_PIPE (0..MUL_PIPE_MAX) register stages;
// product, valid and last travel together and all stages freeze when en=0.
module mac_mult_pipe import mac_pkg::*; #(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int MUL_PIPE   = MUL_PIPE_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    input  logic                           valid,
    input  logic                           last,
    output logic signed [2*DATA_WIDTH-1:0] prod,
    output logic                           prod_valid,
    output logic                           prod_last
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod_in;

    assign prod_in = PW'(a) * PW'(b);

    generate
        if (MUL_PIPE == 0) begin : g_comb
            assign prod       = prod_in;
            assign prod_valid = valid;
            assign prod_last  = last;
        end else begin : g_pipe
            logic [MUL_PIPE-1:0][PW-1:0] prod_pipe;
            logic [MUL_PIPE-1:0]         vld_pipe;
            logic [MUL_PIPE-1:0]         last_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    prod_pipe <= '0;
                    vld_pipe  <= '0;
                    last_pipe <= '0;
                end else if (en) begin
                    prod_pipe[0] <= prod_in;
                    vld_pipe[0]  <= valid;
                    last_pipe[0] <= last;
                    for (int s = 1; s < MUL_PIPE; s++) begin
                        prod_pipe[s] <= prod_pipe[s-1];
                        vld_pipe[s]  <= vld_pipe[s-1];
                        last_pipe[s] <= last_pipe[s-1];
                    end
                end
            end

            assign prod       = $signed(prod_pipe[MUL_PIPE-1]);
            assign prod_valid = vld_pipe[MUL_PIPE-1];
            assign prod_last  = last_pipe[MUL_PIPE-1];
        end
    endgenerate

endmodule

// File: rtl/mac_pe_os.sv
// Output-stationary MAC processing element: forwards operands, accumulates signed
// products per dot product, and merges local results with a neighbour drain chain.
module mac_pe_os import mac_pkg::*; #(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ACC_WIDTH  = ACC_W_DEF,
    parameter int OUT_WIDTH  = OUT_W_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int MUL_PIPE   = MUL_PIPE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] iv_a,
    input  logic [DATA_WIDTH-1:0] iv_b,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] ov_a,
    output logic [DATA_WIDTH-1:0] ov_b,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic [OUT_WIDTH-1:0]  iv_drain,
    input  logic                  i_drain_valid,
    output logic                  o_drain_ready,
    output logic [OUT_WIDTH-1:0]  ov_result,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod;
    logic                        prod_valid;
    logic                        prod_last;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] final_val;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        final_vld;
    logic [OUT_WIDTH-1:0]        narrowed;
    logic [OUT_WIDTH-1:0]        local_res;
    logic                        local_vld;
    logic [OUT_WIDTH-1:0]        hold_res;
    logic                        hold_vld;
    logic                        out_free;
    logic                        drain_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_a    <= '0;
            ov_b    <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (i_en) begin
            ov_a    <= iv_a;
            ov_b    <= iv_b;
            o_valid <= i_valid;
            o_last  <= i_last;
        end
    end

    mac_mult_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_PIPE   (MUL_PIPE)
    ) u_mult (
        .clk        (i_clk),
        .rst        (i_rst),
        .en         (i_en),
        .a          (iv_a),
        .b          (iv_b),
        .valid      (i_valid),
        .last       (i_last),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_last  (prod_last)
    );

    assign prod_ext = ACC_WIDTH'(prod);
    assign sum      = acc + prod_ext;

    // The closing product is folded into the captured sum while acc restarts from 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            final_val <= '0;
            final_vld <= 1'b0;
        end else if (i_en) begin
            final_vld <= prod_valid & prod_last;
            if (prod_valid) begin
                if (prod_last) begin
                    final_val <= sum;
                    acc       <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    assign shifted  = final_val >>> FRAC_BITS;
    assign narrowed = OUT_WIDTH'(narrow_word(ACC_MAX_W'(shifted), OUT_WIDTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            local_res <= '0;
            local_vld <= 1'b0;
        end else if (i_en) begin
            local_res <= narrowed;
            local_vld <= final_vld;
        end
    end

    assign o_drain_ready = !hold_vld && !local_vld;
    assign out_free      = !o_result_valid || i_result_ready;
    assign drain_acc     = i_drain_valid && o_drain_ready && i_en;

    // Output load priority: local result, then hold, then drain. A drain word is only
    // accepted while hold is empty and no local result competes, so it never gets lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_result      <= '0;
            o_result_valid <= 1'b0;
            hold_res       <= '0;
            hold_vld       <= 1'b0;
            o_ovf          <= 1'b0;
        end else if (i_en) begin
            if (out_free) begin
                if (local_vld) begin
                    ov_result      <= local_res;
                    o_result_valid <= 1'b1;
                end else if (hold_vld) begin
                    ov_result      <= hold_res;
                    o_result_valid <= 1'b1;
                    hold_vld       <= 1'b0;
                end else if (drain_acc) begin
                    ov_result      <= iv_drain;
                    o_result_valid <= 1'b1;
                end else begin
                    o_result_valid <= 1'b0;
                end
            end else if (local_vld) begin
                if (!hold_vld) begin
                    hold_res <= local_res;
                    hold_vld <= 1'b1;
                end else begin
                    o_ovf <= 1'b1;
                end
            end else if (drain_acc) begin
                hold_res <= iv_drain;
                hold_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_os.sv
// Directed self-checking bench for mac_pe_os at default parameters (MUL_PIPE=1).
// Honours MAC_SAT_EN when selecting the expected narrowed value.
module tb_mac_pe_os;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_en = 1'b1;
    logic [15:0] iv_a = '0;
    logic [15:0] iv_b = '0;
    logic        i_valid = 1'b0;
    logic        i_last = 1'b0;
    logic [15:0] ov_a;
    logic [15:0] ov_b;
    logic        o_valid;
    logic        o_last;
    logic [15:0] iv_drain = '0;
    logic        i_drain_valid = 1'b0;
    logic        o_drain_ready;
    logic [15:0] ov_result;
    logic        o_result_valid;
    logic        i_result_ready = 1'b1;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

    mac_pe_os dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (i_en),
        .iv_a           (iv_a),
        .iv_b           (iv_b),
        .i_valid        (i_valid),
        .i_last         (i_last),
        .ov_a           (ov_a),
        .ov_b           (ov_b),
        .o_valid        (o_valid),
        .o_last         (o_last),
        .iv_drain       (iv_drain),
        .i_drain_valid  (i_drain_valid),
        .o_drain_ready  (o_drain_ready),
        .ov_result      (ov_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_ovf          (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input logic v, input logic l);
        iv_a    = 16'(a);
        iv_b    = 16'(b);
        i_valid = v;
        i_last  = l;
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(7, 7, 1'b1, 1'b1);
        i_drain_valid = 1'b1;
        iv_drain = 16'h0055;
        step();
        step();
        checks++;
        if ({ov_a, ov_b, o_valid, o_last} !== 34'd0) begin
            errors++;
            $display("FAIL reset_fwd: got %h expected 0", {ov_a, ov_b, o_valid, o_last});
        end
        checks++;
        if ({ov_result, o_result_valid, o_ovf} !== 18'd0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", {ov_result, o_result_valid, o_ovf});
        end
        checks++;
        if (o_drain_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_drain_ready: got %b expected 1", o_drain_ready);
        end
        i_rst = 1'b0;
        i_drain_valid = 1'b0;
        idle();
        step();
    endtask

    task automatic test_forward();
        drive(5, -3, 1'b1, 1'b1);
        step();
        checks++;
        if ({ov_a, ov_b, o_valid, o_last} !== {16'h0005, 16'hFFFD, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL forward: got %h expected %h", {ov_a, ov_b, o_valid, o_last},
                     {16'h0005, 16'hFFFD, 1'b1, 1'b1});
        end
        idle();
        step();
        step();
        checks++;
        if (o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: o_result_valid got %b expected 0", o_result_valid);
        end
        step();
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, 16'hFFF1}) begin
            errors++;
            $display("FAIL single_neg: got %h expected %h", {o_result_valid, ov_result}, {1'b1, 16'hFFF1});
        end
        step();
        checks++;
        if (o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consumed: o_result_valid got %b expected 0", o_result_valid);
        end
    endtask

    task automatic test_dot();
        drive(3, 4, 1'b1, 1'b0);
        step();
        drive(-2, 5, 1'b1, 1'b0);
        step();
        drive(7, 1, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        checks++;
        if (o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL dot_early: o_result_valid got %b expected 0", o_result_valid);
        end
        checks++;
        if (dut.acc !== 40'sd0) begin
            errors++;
            $display("FAIL dot_acc_clear: got %h expected 0", dut.acc);
        end
        step();
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, 16'd9}) begin
            errors++;
            $display("FAIL dot_result: got %h expected %h", {o_result_valid, ov_result}, {1'b1, 16'd9});
        end
        step();
    endtask

    task automatic test_narrow();
        logic [15:0] exp;
`ifdef MAC_SAT_EN
        exp = 16'h7FFF;
`else
        exp = 16'h0002;
`endif
        drive(32767, 32767, 1'b1, 1'b0);
        step();
        drive(32767, 32767, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        step();
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL narrow: got %h expected %h", {o_result_valid, ov_result}, {1'b1, exp});
        end
        step();
    endtask

    task automatic test_drain_merge();
        drive(17, 1, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        i_drain_valid = 1'b1;
        iv_drain = 16'h00AA;
        #1;
        checks++;
        if (o_drain_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_blocked: o_drain_ready got %b expected 0", o_drain_ready);
        end
        step();
        checks++;
        if ({o_result_valid, ov_result, o_drain_ready} !== {1'b1, 16'h0011, 1'b1}) begin
            errors++;
            $display("FAIL drain_local_first: got %h expected %h", {o_result_valid, ov_result, o_drain_ready},
                     {1'b1, 16'h0011, 1'b1});
        end
        step();
        i_drain_valid = 1'b0;
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, 16'h00AA}) begin
            errors++;
            $display("FAIL drain_word: got %h expected %h", {o_result_valid, ov_result}, {1'b1, 16'h00AA});
        end
        step();
        checks++;
        if (o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: o_result_valid got %b expected 0", o_result_valid);
        end
    endtask

    task automatic test_overflow();
        i_result_ready = 1'b0;
        drive(1, 1, 1'b1, 1'b1);
        step();
        drive(2, 1, 1'b1, 1'b1);
        step();
        drive(3, 1, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        checks++;
        if ({o_ovf, o_drain_ready, o_result_valid, ov_result} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL ovf_hold: got %h expected %h", {o_ovf, o_drain_ready, o_result_valid, ov_result},
                     {1'b0, 1'b0, 1'b1, 16'd1});
        end
        step();
        checks++;
        if ({o_ovf, o_result_valid, ov_result} !== {1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL ovf_drop: got %h expected %h", {o_ovf, o_result_valid, ov_result},
                     {1'b1, 1'b1, 16'd1});
        end
        i_result_ready = 1'b1;
        step();
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL ovf_second: got %h expected %h", {o_result_valid, ov_result}, {1'b1, 16'd2});
        end
        step();
        checks++;
        if ({o_result_valid, o_ovf, o_drain_ready} !== 3'b011) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 011", {o_result_valid, o_ovf, o_drain_ready});
        end
    endtask

    task automatic test_freeze();
        drive(3, 4, 1'b1, 1'b0);
        step();
        drive(-2, 5, 1'b1, 1'b0);
        step();
        i_en = 1'b0;
        drive(100, 100, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({ov_a, ov_b, o_valid, o_last, o_result_valid} !== {16'hFFFE, 16'h0005, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL freeze_cycle%0d: got %h expected %h", c,
                         {ov_a, ov_b, o_valid, o_last, o_result_valid},
                         {16'hFFFE, 16'h0005, 1'b1, 1'b0, 1'b0});
            end
        end
        i_en = 1'b1;
        drive(7, 1, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        step();
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, 16'd9}) begin
            errors++;
            $display("FAIL freeze_result: got %h expected %h", {o_result_valid, ov_result}, {1'b1, 16'd9});
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(10, 10, 1'b1, 1'b0);
        step();
        drive(20, 20, 1'b1, 1'b0);
        step();
        i_rst = 1'b1;
        i_en = 1'b0;
        step();
        checks++;
        if ({ov_a, ov_b, o_valid, o_last, ov_result, o_result_valid, o_ovf} !== 52'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {ov_a, ov_b, o_valid, o_last, ov_result, o_result_valid, o_ovf});
        end
        checks++;
        if ({o_drain_ready, dut.acc} !== {1'b1, 40'd0}) begin
            errors++;
            $display("FAIL midreset_state: got %h expected %h", {o_drain_ready, dut.acc}, {1'b1, 40'd0});
        end
        i_rst = 1'b0;
        i_en = 1'b1;
        drive(1, 2, 1'b1, 1'b0);
        step();
        drive(3, 4, 1'b1, 1'b0);
        step();
        drive(5, 6, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        step();
        checks++;
        if ({o_result_valid, ov_result} !== {1'b1, 16'd44}) begin
            errors++;
            $display("FAIL midreset_sum: got %h expected %h", {o_result_valid, ov_result}, {1'b1, 16'd44});
        end
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_forward();
        test_dot();
        test_narrow();
        test_drain_merge();
        test_overflow();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
